// File: rtl/namuru_dump_sequencer.sv
// namuru_dump_sequencer
// Readout scheduler for the Namuru correlator array. Latches per-channel dump
// events, snapshots them on each accumulation tick, then walks every dumped
// channel through the shared accumulator readout mux and copies its six I/Q
// early/prompt/late words into a snapshot RAM that firmware reads coherently.
//
// Ports:
//   correlator_clk  clock
//   rstn            synchronous active-low reset
//   accum_tick      accumulation-interval pulse; starts a snapshot when idle
//   ch_dump         per-channel dump pulses
//   acc_data        accumulator word for ch_sel/word_sel (valid cycle after select)
//   ch_sel          channel driven onto the shared readout mux
//   word_sel        word select 0..5 = iE,qE,iP,qP,iL,qL
//   rd_addr         snapshot RAM read address {ch, word}
//   rd_data         snapshot RAM read data, 1-cycle latency
//   ready_mask      channels captured in last completed snapshot
//   busy            sequence in progress
//   irq             snapshot complete, held until irq_clr
//   irq_clr         clears irq and overrun
//   overrun         sticky: tick arrived while busy
//
// Optional build macro NAMURU_DUMP_SEQ_TIMESTAMP_EN adds tic_count input and
// snap_tic output carrying the tic count sampled when the snapshot started.

module namuru_dump_sequencer #(
  parameter int unsigned NUM_CH  = 12,
  parameter int unsigned CH_BITS = 4
) (
  input  logic                 correlator_clk,
  input  logic                 rstn,
  input  logic                 accum_tick,
  input  logic [NUM_CH-1:0]    ch_dump,
  input  logic [15:0]          acc_data,
  output logic [CH_BITS-1:0]   ch_sel,
  output logic [2:0]           word_sel,
  input  logic [CH_BITS+2:0]   rd_addr,
  output logic [15:0]          rd_data,
  output logic [NUM_CH-1:0]    ready_mask,
  output logic                 busy,
  output logic                 irq,
  input  logic                 irq_clr,
  output logic                 overrun
`ifdef NAMURU_DUMP_SEQ_TIMESTAMP_EN
  ,
  input  logic [23:0]          tic_count,
  output logic [23:0]          snap_tic
`endif
);

  localparam int unsigned ADDR_W  = CH_BITS + 3;
  localparam int unsigned DEPTH   = 1 << ADDR_W;
  localparam int unsigned CH_SPAN = 1 << CH_BITS;
  localparam int unsigned LAST_WORD = 5;

  typedef enum logic [2:0] {IDLE, SCAN, SEL, WR, DONE} state_t;

  state_t              state, state_nxt;
  logic [CH_BITS-1:0]  ch_idx, ch_idx_nxt;
  logic [2:0]          word, word_nxt;
  logic [NUM_CH-1:0]   snap, snap_nxt;
  logic [NUM_CH-1:0]   pending, pending_nxt;
  logic [CH_BITS-1:0]  ch_sel_nxt;
  logic [2:0]          word_sel_nxt;
  logic [NUM_CH-1:0]   ready_mask_nxt;
  logic                busy_nxt, irq_nxt, overrun_nxt;

  logic [CH_SPAN-1:0]  snap_ext;
  logic                snap_bit;
  logic                last_ch;
  logic                last_word;

  logic [15:0]         mem [DEPTH];

  // Zero-extend snap so any ch_idx value indexes a defined bit.
  assign snap_ext  = CH_SPAN'(snap);
  assign snap_bit  = snap_ext[ch_idx];
  assign last_ch   = (ch_idx == CH_BITS'(NUM_CH - 1));
  assign last_word = (word == 3'(LAST_WORD));

  // State and output registers.
  always_ff @(posedge correlator_clk) begin
    if (!rstn) begin
      state      <= IDLE;
      ch_idx     <= '0;
      word       <= '0;
      snap       <= '0;
      pending    <= '0;
      ch_sel     <= '0;
      word_sel   <= '0;
      ready_mask <= '0;
      busy       <= 1'b0;
      irq        <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      state      <= state_nxt;
      ch_idx     <= ch_idx_nxt;
      word       <= word_nxt;
      snap       <= snap_nxt;
      pending    <= pending_nxt;
      ch_sel     <= ch_sel_nxt;
      word_sel   <= word_sel_nxt;
      ready_mask <= ready_mask_nxt;
      busy       <= busy_nxt;
      irq        <= irq_nxt;
      overrun    <= overrun_nxt;
    end
  end

  // Next-state and next-output logic.
  always_comb begin
    state_nxt      = state;
    ch_idx_nxt     = ch_idx;
    word_nxt       = word;
    snap_nxt       = snap;
    pending_nxt    = pending | ch_dump;
    ch_sel_nxt     = ch_sel;
    word_sel_nxt   = word_sel;
    ready_mask_nxt = ready_mask;
    busy_nxt       = busy;
    irq_nxt        = irq;
    overrun_nxt    = overrun;

    if (irq_clr) begin
      irq_nxt     = 1'b0;
      overrun_nxt = 1'b0;
    end

    // A tick outside IDLE is dropped; dumps keep accumulating in pending.
    if (accum_tick && (state != IDLE)) begin
      overrun_nxt = 1'b1;
    end

    case (state)
      IDLE: begin
        if (accum_tick) begin
          // Same-cycle dumps belong to this snapshot, not the next one.
          snap_nxt    = pending | ch_dump;
          pending_nxt = '0;
          ch_idx_nxt  = '0;
          busy_nxt    = 1'b1;
          state_nxt   = SCAN;
        end
      end
      SCAN: begin
        if (snap_bit) begin
          word_nxt  = '0;
          state_nxt = SEL;
        end else if (last_ch) begin
          state_nxt = DONE;
        end else begin
          ch_idx_nxt = ch_idx + CH_BITS'(1);
        end
      end
      SEL: begin
        ch_sel_nxt   = ch_idx;
        word_sel_nxt = word;
        state_nxt    = WR;
      end
      WR: begin
        if (last_word) begin
          if (last_ch) begin
            state_nxt = DONE;
          end else begin
            ch_idx_nxt = ch_idx + CH_BITS'(1);
            state_nxt  = SCAN;
          end
        end else begin
          word_nxt  = word + 3'(1);
          state_nxt = SEL;
        end
      end
      DONE: begin
        // Setting irq here takes priority over a coincident irq_clr.
        ready_mask_nxt = snap;
        irq_nxt        = 1'b1;
        busy_nxt       = 1'b0;
        state_nxt      = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Snapshot RAM write port; contents are deliberately not reset.
  always_ff @(posedge correlator_clk) begin
    if (state == WR) begin
      mem[{ch_idx, word}] <= acc_data;
    end
  end

  // Registered read port; a same-cycle write returns the previous word.
  always_ff @(posedge correlator_clk) begin
    if (!rstn) begin
      rd_data <= '0;
    end else begin
      rd_data <= mem[rd_addr];
    end
  end

`ifdef NAMURU_DUMP_SEQ_TIMESTAMP_EN
  logic [23:0] ts_word;

  // Timestamp sampled at snapshot start, published at completion.
  always_ff @(posedge correlator_clk) begin
    if (!rstn) begin
      ts_word  <= '0;
      snap_tic <= '0;
    end else begin
      if ((state == IDLE) && accum_tick) begin
        ts_word <= tic_count;
      end
      if (state == DONE) begin
        snap_tic <= ts_word;
      end
    end
  end
`endif

endmodule

// File: tb/tb_namuru_dump_sequencer.sv
// Self-checking bench for namuru_dump_sequencer: directed scenarios followed
// by randomized snapshots compared against a queue/array reference model.

module tb_namuru_dump_sequencer;

  localparam int unsigned NUM_CH  = 12;
  localparam int unsigned CH_BITS = 4;
  localparam int unsigned AW      = CH_BITS + 3;

  logic                correlator_clk = 1'b0;
  logic                rstn = 1'b0;
  logic                accum_tick = 1'b0;
  logic [NUM_CH-1:0]   ch_dump = '0;
  logic [15:0]         acc_data;
  logic [CH_BITS-1:0]  ch_sel;
  logic [2:0]          word_sel;
  logic [AW-1:0]       rd_addr = '0;
  logic [15:0]         rd_data;
  logic [NUM_CH-1:0]   ready_mask;
  logic                busy;
  logic                irq;
  logic                irq_clr = 1'b0;
  logic                overrun;
  logic [4:0]          epoch = '0;

`ifdef NAMURU_DUMP_SEQ_TIMESTAMP_EN
  logic [23:0] tic_count = '0;
  logic [23:0] snap_tic;
  always @(posedge correlator_clk) tic_count <= tic_count + 24'd1;
`endif

  always #5 correlator_clk = ~correlator_clk;

  // Accumulator bank stand-in: word value encodes epoch, channel and word.
  assign acc_data = {epoch, ch_sel, 4'h0, word_sel};

  namuru_dump_sequencer #(.NUM_CH(NUM_CH), .CH_BITS(CH_BITS)) dut (
    .correlator_clk (correlator_clk),
    .rstn           (rstn),
    .accum_tick     (accum_tick),
    .ch_dump        (ch_dump),
    .acc_data       (acc_data),
    .ch_sel         (ch_sel),
    .word_sel       (word_sel),
    .rd_addr        (rd_addr),
    .rd_data        (rd_data),
    .ready_mask     (ready_mask),
    .busy           (busy),
    .irq            (irq),
    .irq_clr        (irq_clr),
    .overrun        (overrun)
`ifdef NAMURU_DUMP_SEQ_TIMESTAMP_EN
    ,
    .tic_count      (tic_count),
    .snap_tic       (snap_tic)
`endif
  );

  // Reference model state.
  logic [NUM_CH-1:0] pend_m = '0;
  logic [15:0]       mem_m [1 << AW];
  bit                vld_m [1 << AW];
  int                vectors = 0;
  int                miscompares = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge correlator_clk);
    #1;
  endtask

  task automatic dump_pulse(input logic [NUM_CH-1:0] m);
    ch_dump = m;
    pend_m  = pend_m | m;
    step();
    ch_dump = '0;
  endtask

  task automatic read_chk(input logic [AW-1:0] a, input logic [15:0] exp);
    rd_addr = a;
    step();
    chk($sformatf("ram[%0h]", a), rd_data, exp);
  endtask

  task automatic clr_irq();
    irq_clr = 1'b1;
    step();
    irq_clr = 1'b0;
    chk("irq_after_clr", irq, 0);
    chk("overrun_after_clr", overrun, 0);
  endtask

  // One snapshot: duration is one cycle per channel visit, twelve more per
  // captured channel, plus the completion cycle.
  task automatic run_snap(input logic [NUM_CH-1:0] tick_dump, input int second_tick_at,
                          input bit clr_at_done, input bit rand_dumps);
    logic [NUM_CH-1:0] snap_m;
    logic [NUM_CH-1:0] rd;
    int d;
    bit ovr_m;
    logic [AW-1:0] a;
    snap_m = pend_m | tick_dump;
    pend_m = '0;
    d      = NUM_CH + 12 * $countones(snap_m) + 1;
    ovr_m  = 1'b0;
    accum_tick = 1'b1;
    ch_dump    = tick_dump;
    step();
    accum_tick = 1'b0;
    ch_dump    = '0;
    chk("busy_at_tick", busy, 1);
    for (int k = 1; k <= d; k++) begin
      if (rand_dumps && ($urandom_range(3) == 0)) begin
        rd = NUM_CH'($urandom) & NUM_CH'($urandom);
        ch_dump = rd;
        pend_m  = pend_m | rd;
      end
      if (k == second_tick_at) begin
        accum_tick = 1'b1;
        ovr_m      = 1'b1;
      end
      if ((k == d) && clr_at_done) irq_clr = 1'b1;
      step();
      ch_dump = '0; accum_tick = 1'b0; irq_clr = 1'b0;
      if (k == d - 1) begin
        chk("irq_before_done", irq, 0);
        chk("busy_before_done", busy, 1);
      end
    end
    if (clr_at_done) ovr_m = 1'b0;
    chk("irq_at_done", irq, 1);
    chk("busy_at_done", busy, 0);
    chk("ready_mask", ready_mask, snap_m);
    chk("overrun", overrun, ovr_m);
    for (int ch = 0; ch < NUM_CH; ch++) begin
      if (snap_m[ch]) begin
        for (int w = 0; w < 6; w++) begin
          a = AW'(ch * 8 + w);
          mem_m[a] = {epoch, 4'(ch), 4'h0, 3'(w)};
          vld_m[a] = 1'b1;
        end
      end
    end
    for (int ch = 0; ch < NUM_CH; ch++) begin
      if (snap_m[ch]) begin
        for (int w = 0; w < 6; w++) begin
          a = AW'(ch * 8 + w);
          read_chk(a, mem_m[a]);
        end
      end
    end
    // Older captures must survive untouched.
    for (int n = 0; n < 4; n++) begin
      a = AW'($urandom_range((1 << AW) - 1));
      if (vld_m[a]) read_chk(a, mem_m[a]);
    end
  endtask

  initial begin
    for (int i = 0; i < (1 << AW); i++) vld_m[i] = 1'b0;

    // Reset values.
    step(); step(); step();
    chk("rst_busy", busy, 0);
    chk("rst_irq", irq, 0);
    chk("rst_overrun", overrun, 0);
    chk("rst_ready_mask", ready_mask, 0);
    chk("rst_ch_sel", ch_sel, 0);
    chk("rst_word_sel", word_sel, 0);
    chk("rst_rd_data", rd_data, 0);
    rstn = 1'b1;
    step();

    // Single channel 0.
    dump_pulse(12'h001);
    run_snap('0, 0, 1'b0, 1'b0);
    read_chk(7'h00, 16'h0000);
    read_chk(7'h05, 16'h0005);
    clr_irq();

    // Channels 3 and 11.
    dump_pulse(12'h008);
    dump_pulse(12'h800);
    run_snap('0, 0, 1'b0, 1'b0);
    read_chk(7'h1a, 16'h0182);
    read_chk(7'h5d, 16'h0585);
    clr_irq();

    // Dump coincident with tick lands in this snapshot.
    epoch = 5'd1;
    run_snap(12'h020, 0, 1'b0, 1'b0);
    clr_irq();

    // Second tick while busy: overrun, no restart.
    epoch = 5'd2;
    dump_pulse(12'h080);
    run_snap('0, 5, 1'b0, 1'b0);
    clr_irq();

    // Empty snapshot (also proves pending was drained) with irq_clr on DONE.
    run_snap('0, 0, 1'b1, 1'b0);

    // Reset while channel 2 is in SEL.
    dump_pulse(12'h004);
    accum_tick = 1'b1;
    step();
    accum_tick = 1'b0;
    pend_m = '0;
    step(); step(); step();
    rstn = 1'b0;
    step();
    chk("abort_busy", busy, 0);
    chk("abort_irq", irq, 0);
    chk("abort_ch_sel", ch_sel, 0);
    chk("abort_ready_mask", ready_mask, 0);
    rstn = 1'b1;
    epoch = 5'd3;
    dump_pulse(12'h204);
    run_snap('0, 0, 1'b0, 1'b0);
    clr_irq();

    // Randomized snapshots.
    for (int it = 0; it < 20; it++) begin
      epoch = 5'($urandom);
      for (int p = 0; p < 3; p++) dump_pulse(NUM_CH'($urandom) & NUM_CH'($urandom));
      run_snap(NUM_CH'($urandom) & NUM_CH'($urandom) & NUM_CH'($urandom),
               ($urandom_range(3) == 0) ? int'($urandom_range(1, 10)) : 0,
               1'b0, 1'b1);
      clr_irq();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
